// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin burst arbiter for the push side of one FIFO.
// Tracks FIFO occupancy from its own pushes and the consumer's pops, and only
// grants a beat when the FIFO has room. Grants are combinational (zero latency).
// Optional macro FIFO_ARB_STATS_EN adds per-requester saturating grant counters.
module fifo_push_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DEPTH     = 16,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*DW-1:0]        data_i,
  input  logic                       pop_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic                       push_o,
  output logic [DW-1:0]              wdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  input  logic [$clog2(N_REQ)-1:0]   stat_sel_i,
  output logic [15:0]                stat_cnt_o
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BURST_MAX + 1);

  localparam logic [PW:0]   N_EXT    = (PW+1)'(N_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [BW-1:0] BURST_C  = BW'(BURST_MAX);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]   count_q, count_d;

  logic [PW:0]     sum_s;
  logic [PW:0]     scan_s;
  logic [PW-1:0]   win_s;
  logic            win_vld_s;
  logic [PW-1:0]   gnt_idx_s;
  logic            grant_s;
  logic            full_s;
  logic            empty_s;
  logic            pop_eff_s;

  // Advance a requester pointer by one, wrapping at N_REQ.
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    if (p == LAST_IDX) begin
      inc_ptr = {PW{1'b0}};
    end else begin
      inc_ptr = p + PW'(1);
    end
  endfunction

  assign full_s    = (count_q == DEPTH_C);
  assign empty_s   = (count_q == {CW{1'b0}});
  assign pop_eff_s = pop_i && !empty_s;

  // Round-robin scan: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    win_vld_s = 1'b0;
    win_s     = {PW{1'b0}};
    sum_s     = {(PW+1){1'b0}};
    scan_s    = {(PW+1){1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      sum_s  = {1'b0, rr_ptr_q} + (PW+1)'(i);
      scan_s = (sum_s >= N_EXT) ? (sum_s - N_EXT) : sum_s;
      if (!win_vld_s && req_i[scan_s[PW-1:0]]) begin
        win_vld_s = 1'b1;
        win_s     = scan_s[PW-1:0];
      end else begin
        win_s     = win_s;
      end
    end
  end

  // Arbitration FSM next state plus the grant decision for this cycle.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    grant_s    = 1'b0;
    gnt_idx_s  = owner_q;
    if (rst_i) begin
      state_d    = IDLE;
      rr_ptr_d   = {PW{1'b0}};
      owner_d    = {PW{1'b0}};
      beat_cnt_d = {BW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_s && !full_s) begin
            grant_s    = 1'b1;
            gnt_idx_s  = win_s;
            owner_d    = win_s;
            beat_cnt_d = BW'(1);
            // A single-beat burst re-arbitrates immediately without leaving IDLE.
            if (BURST_MAX == 32'sd1) begin
              rr_ptr_d = inc_ptr(win_s);
            end else begin
              state_d  = BURST;
            end
          end else begin
            state_d = IDLE;
          end
        end
        BURST: begin
          if (req_i[owner_q] && !full_s) begin
            grant_s    = 1'b1;
            beat_cnt_d = beat_cnt_q + BW'(1);
            if ((beat_cnt_q + BW'(1)) == BURST_C) begin
              state_d  = IDLE;
              rr_ptr_d = inc_ptr(owner_q);
            end else begin
              state_d  = BURST;
            end
          end else if (!req_i[owner_q]) begin
            // Owner dropped its request: end the burst without a beat.
            state_d  = IDLE;
            rr_ptr_d = inc_ptr(owner_q);
          end else begin
            // FIFO full with request held: wait, keep the beat count.
            state_d  = BURST;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Write-port drive: one-hot grant and the granted requester's data slice.
  always_comb begin
    gnt_o   = {N_REQ{1'b0}};
    wdata_o = {DW{1'b0}};
    if (grant_s) begin
      gnt_o[gnt_idx_s] = 1'b1;
      wdata_o          = data_i[gnt_idx_s*DW +: DW];
    end else begin
      wdata_o          = {DW{1'b0}};
    end
  end

  assign push_o  = grant_s;
  assign count_o = count_q;
  assign full_o  = full_s;
  assign empty_o = empty_s;

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (grant_s && !pop_eff_s) begin
      count_d = count_q + CW'(1);
    end else if (!grant_s && pop_eff_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= {PW{1'b0}};
      owner_q    <= {PW{1'b0}};
      beat_cnt_q <= {BW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      count_q    <= count_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [N_REQ];
  logic [15:0] stat_d [N_REQ];

  // Per-requester grant counters, saturating at all-ones.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      stat_d[k] = stat_q[k];
      if (gnt_o[k] && (stat_q[k] != 16'hFFFF)) begin
        stat_d[k] = stat_q[k] + 16'd1;
      end else begin
        stat_d[k] = stat_q[k];
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_REQ; k++) begin
        stat_q[k] <= 16'd0;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        stat_q[k] <= stat_d[k];
      end
    end
  end

  // Statistics readout; out-of-range selects read as zero.
  always_comb begin
    stat_cnt_o = 16'd0;
    if ({1'b0, stat_sel_i} < N_EXT) begin
      stat_cnt_o = stat_q[stat_sel_i];
    end else begin
      stat_cnt_o = 16'd0;
    end
  end
`else
  logic unused_stat_sel_s;
  assign unused_stat_sel_s = ^stat_sel_i;
  assign stat_cnt_o        = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter. Two instances share one stimulus:
// index 0 uses BURST_MAX=4, index 1 uses BURST_MAX=1. A queue-free behavioural
// model predicts grants/data/occupancy each cycle; directed literals pin it.
// Define FIFO_ARB_STATS_EN to exercise the statistics counters.
module tb_fifo_push_arbiter;
  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic        pop;
  logic [1:0]  sel;

  logic [3:0]  gnt_a   [2];
  logic        push_a  [2];
  logic [7:0]  wd_a    [2];
  logic [4:0]  cnt_a   [2];
  logic        full_a  [2];
  logic        empty_a [2];
  logic [15:0] st_a    [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // model state
  int bm [2] = '{4, 1};
  int m_burst [2];
  int m_owner [2];
  int m_beats [2];
  int m_rr    [2];
  int m_cnt   [2];
  int m_stat  [2][4];
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  fifo_push_arbiter #(.N_REQ(N), .DEPTH(DEPTH), .DW(DW), .BURST_MAX(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .pop_i(pop),
    .gnt_o(gnt_a[0]), .push_o(push_a[0]), .wdata_o(wd_a[0]), .count_o(cnt_a[0]),
    .full_o(full_a[0]), .empty_o(empty_a[0]), .stat_sel_i(sel), .stat_cnt_o(st_a[0])
  );

  fifo_push_arbiter #(.N_REQ(N), .DEPTH(DEPTH), .DW(DW), .BURST_MAX(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .pop_i(pop),
    .gnt_o(gnt_a[1]), .push_o(push_a[1]), .wdata_o(wd_a[1]), .count_o(cnt_a[1]),
    .full_o(full_a[1]), .empty_o(empty_a[1]), .stat_sel_i(sel), .stat_cnt_o(st_a[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Which requester must be granted now (-1 for none), from the arbitration rules.
  function automatic int exp_win(input int k);
    int j;
    if (rst) return -1;
    if (m_cnt[k] >= DEPTH) return -1;
    if (m_burst[k] != 0) return req[m_owner[k]] ? m_owner[k] : -1;
    for (int i = 0; i < N; i++) begin
      j = (m_rr[k] + i) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int w [2];
    bit popok;
    for (int k = 0; k < 2; k++) w[k] = exp_win(k);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_burst[k] = 0; m_owner[k] = 0; m_beats[k] = 0; m_rr[k] = 0; m_cnt[k] = 0;
        for (int s = 0; s < N; s++) m_stat[k][s] = 0;
      end else begin
        popok = pop && (m_cnt[k] > 0);
        m_cnt[k] = m_cnt[k] + ((w[k] >= 0) ? 1 : 0) - (popok ? 1 : 0);
        if (w[k] >= 0) begin
          if (m_stat[k][w[k]] < 65535) m_stat[k][w[k]]++;
          if (m_burst[k] == 0) begin
            m_owner[k] = w[k];
            m_beats[k] = 1;
            if (bm[k] == 1) m_rr[k] = (w[k] + 1) % N;
            else m_burst[k] = 1;
          end else begin
            m_beats[k]++;
            if (m_beats[k] == bm[k]) begin
              m_burst[k] = 0;
              m_rr[k] = (m_owner[k] + 1) % N;
            end
          end
        end else if ((m_burst[k] != 0) && !req[m_owner[k]]) begin
          m_burst[k] = 0;
          m_rr[k] = (m_owner[k] + 1) % N;
        end
      end
    end
    m_valid = 1'b1;
  endtask

  // Compare every DUT output against the model once per cycle.
  task automatic compare_all();
    int w;
    logic [31:0] eg, ew, es;
    for (int k = 0; k < 2; k++) begin
      w  = exp_win(k);
      eg = (w >= 0) ? (32'd1 << w) : 32'd0;
      ew = (w >= 0) ? {24'd0, data[w*8 +: 8]} : 32'd0;
`ifdef FIFO_ARB_STATS_EN
      es = m_stat[k][sel];
`else
      es = 32'd0;
`endif
      chk($sformatf("gnt%0d", k),   gnt_a[k],   eg);
      chk($sformatf("push%0d", k),  push_a[k],  (w >= 0) ? 32'd1 : 32'd0);
      chk($sformatf("wdata%0d", k), wd_a[k],    ew);
      chk($sformatf("count%0d", k), cnt_a[k],   m_cnt[k]);
      chk($sformatf("full%0d", k),  full_a[k],  (m_cnt[k] == DEPTH) ? 32'd1 : 32'd0);
      chk($sformatf("empty%0d", k), empty_a[k], (m_cnt[k] == 0) ? 32'd1 : 32'd0);
      chk($sformatf("stat%0d", k),  st_a[k],    es);
    end
  endtask

  // Model-based check on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) compare_all();
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    for (int k = 0; k < N; k++) data[k*8 +: 8] = 8'((cyc * 16) + (k * 3) + 1);
    #1;
  endtask

  initial begin
    int e0 [12];
    int e1 [8];
    int g0 [8];
    rst = 1'b1; req = 4'b1111; pop = 1'b0; sel = 2'd2;
    data = 32'h44332211;
    #1;
    chk("rst_gnt_comb", gnt_a[0], 32'd0);
    chk("rst_push_comb", push_a[0], 32'd0);
    tick();
    chk("rst_count", cnt_a[0], 32'd0);
    chk("rst_empty", empty_a[0], 32'd1);
    chk("rst_gnt", gnt_a[0], 32'd0);
    chk("rst_wdata", wd_a[0], 32'd0);
    tick();

    // fairness / first grant after release
    rst = 1'b0; pop = 1'b1;
    #1;
    e1 = '{1, 2, 4, 8, 1, 2, 4, 8};
    g0 = '{1, 1, 1, 1, 2, 2, 2, 2};
    for (int i = 0; i < 8; i++) begin
      chk("rr_bm1_gnt", gnt_a[1], e1[i]);
      chk("rr_bm4_gnt", gnt_a[0], g0[i]);
      chk("rr_bm1_count", cnt_a[1], (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
`ifdef FIFO_ARB_STATS_EN
    chk("stat_fair_req2_bm1", st_a[1], 32'd2);
    chk("stat_fair_req2_bm4", st_a[0], 32'd0);
`endif

    // burst limit with two requesters
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0101;
    #1;
    e0 = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      chk("burst_gnt", gnt_a[0], 32'd1 << e0[i]);
      chk("burst_wdata", wd_a[0], data[e0[i]*8 +: 8]);
      tick();
    end

    // early burst end when owner drops
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0010;
    #1; chk("early_beat1", gnt_a[0], 32'h2);
    tick();
    chk("early_beat2", gnt_a[0], 32'h2);
    req = 4'b1101;
    #1; chk("early_drop", gnt_a[0], 32'h0);
    tick();
    req = 4'b1111;
    #1; chk("early_next_rr", gnt_a[0], 32'h4);
    tick();

    // full / empty boundaries
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0001; pop = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("fill_gnt", gnt_a[0], 32'h1);
      chk("fill_count", cnt_a[0], i);
      tick();
    end
    chk("full_count", cnt_a[0], 32'd16);
    chk("full_flag", full_a[0], 32'd1);
    chk("full_no_gnt", gnt_a[0], 32'd0);
    chk("full_no_push", push_a[0], 32'd0);
    pop = 1'b1;
    #1; chk("full_pop_no_gnt", gnt_a[0], 32'd0);
    tick();
    pop = 1'b0;
    #1;
    chk("after_pop_count", cnt_a[0], 32'd15);
    chk("after_pop_gnt", gnt_a[0], 32'd1);
    tick();
    chk("refull_count", cnt_a[0], 32'd16);
    chk("refull_flag", full_a[0], 32'd1);
    req = 4'b0000; pop = 1'b1;
    repeat (20) tick();
    chk("drain_count", cnt_a[0], 32'd0);
    chk("drain_empty", empty_a[0], 32'd1);

`ifdef FIFO_ARB_STATS_EN
    // saturation of the grant counter
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0001; pop = 1'b1; sel = 2'd0;
    repeat (70000) tick();
    chk("stat_sat_bm4", st_a[0], 32'h0000FFFF);
    chk("stat_sat_bm1", st_a[1], 32'h0000FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
